// File: rtl/tx_status_fifo_mq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tx_status_fifo_mq                                                |
// | Brief   : Transmit-status log FIFO with drop counter, level and threshold  |
// |           interrupt, popped through the AXI-lite register read path.       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tx_status_fifo_mq #(
  parameter int         DEPTH      = 64,
  parameter logic [4:0] POP_ADDR   = 5'h16,
  parameter logic [4:0] STAT_ADDR  = 5'h17,
  parameter int         IRQ_THRESH = 48,
  parameter bit         OVERWRITE  = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        slv_reg_rden,
  input  logic [4:0]  axi_araddr_core,
  input  logic        tx_try_complete,
  input  logic [9:0]  num_slot_random,
  input  logic [3:0]  cw,
  input  logic [4:0]  tx_status,
  input  logic [1:0]  linux_prio,
  input  logic [1:0]  tx_queue_idx,
  input  logic [9:0]  tx_pkt_sn,
  output logic [31:0] tx_status_out,
  output logic [31:0] fifo_stat_out,
  output logic        irq_out
);

  localparam int             c_aw     = $clog2(DEPTH);
  localparam int             c_lw     = c_aw + 1;
  localparam logic [c_lw-1:0] c_depth  = c_lw'(DEPTH);
  localparam logic [c_lw-1:0] c_thresh = c_lw'(IRQ_THRESH);

  logic              r_cap_vld;
  logic [31:0]       r_cap_data;
  logic [31:0]       r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_lw-1:0]   r_level;
  logic [15:0]       r_drop_cnt;
  logic [31:0]       r_tx_status_out;
  logic [31:0]       r_fifo_stat_out;
  logic              r_irq;

  logic [3:0]        w_cwx;
  logic [31:0]       w_cap_rec;
  logic              w_full;
  logic              w_pop;
  logic              w_stat_rd;
  logic              w_drop;
  logic              w_push;
  logic              w_rd_adv;
  logic [c_aw-1:0]   w_wr_ptr_nxt;
  logic [c_aw-1:0]   w_rd_ptr_nxt;
  logic [c_lw-1:0]   w_level_nxt;
  logic [15:0]       w_drop_nxt;
  logic [31:0]       w_head_nxt;
  logic              w_irq_nxt;

  assign w_cwx     = cw + {3'b000, num_slot_random[9]};
  assign w_cap_rec = {w_cwx, num_slot_random[8:0], linux_prio, tx_queue_idx, tx_pkt_sn, tx_status};

  assign w_full    = (r_level == c_depth);
  assign w_pop     = slv_reg_rden && (axi_araddr_core == POP_ADDR) && (r_level != '0);
  assign w_stat_rd = slv_reg_rden && (axi_araddr_core == STAT_ADDR);
  assign w_drop    = r_cap_vld && w_full && !w_pop;
  // In overwrite mode a drop still writes; the oldest entry is pushed out instead.
  assign w_push    = r_cap_vld && (!w_drop || OVERWRITE);
  assign w_rd_adv  = w_pop || (w_drop && OVERWRITE);

  assign w_wr_ptr_nxt = w_push   ? r_wr_ptr + c_aw'(1) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_rd_adv ? r_rd_ptr + c_aw'(1) : r_rd_ptr;
  assign w_level_nxt  = r_level + c_lw'(w_push && !w_drop) - c_lw'(w_pop);
  assign w_irq_nxt    = (w_level_nxt >= c_thresh);

  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (w_stat_rd)
      w_drop_nxt = {15'd0, w_drop};
    else if (w_drop && (r_drop_cnt != 16'hFFFF))
      w_drop_nxt = r_drop_cnt + 16'd1;
  end

  // The new head may be the record being written on this same edge.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_level_nxt == '0)
      w_head_nxt = 32'hFFFF_FFFF;
    else if (w_push && (r_wr_ptr == w_rd_ptr_nxt))
      w_head_nxt = r_cap_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cap_vld  <= 1'b0;
      r_cap_data <= '0;
    end else begin
      r_cap_vld <= tx_try_complete;
      if (tx_try_complete)
        r_cap_data <= w_cap_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= r_cap_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_drop_cnt      <= '0;
      r_tx_status_out <= 32'hFFFF_FFFF;
      r_fifo_stat_out <= '0;
      r_irq           <= 1'b0;
    end else begin
      r_wr_ptr        <= w_wr_ptr_nxt;
      r_rd_ptr        <= w_rd_ptr_nxt;
      r_level         <= w_level_nxt;
      r_drop_cnt      <= w_drop_nxt;
      r_tx_status_out <= w_head_nxt;
      r_fifo_stat_out <= {w_drop_nxt, w_irq_nxt, 4'b0000, 11'(w_level_nxt)};
      r_irq           <= w_irq_nxt;
    end
  end

  assign tx_status_out = r_tx_status_out;
  assign fifo_stat_out = r_fifo_stat_out;
  assign irq_out       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_tx_status_fifo_mq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tx_status_fifo_mq                                             |
// | Brief   : Queue-model bench for three tx_status_fifo_mq configurations.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tx_status_fifo_mq;

  localparam logic [4:0] c_pop  = 5'h16;
  localparam logic [4:0] c_stat = 5'h17;
  localparam int c_mdepth [3]  = '{64, 64, 4};
  localparam int c_mthresh [3] = '{48, 48, 3};
  localparam bit c_mow [3]     = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rstn;
  logic       rden;
  logic [4:0] araddr;
  logic       txc;
  logic [9:0] nsr;
  logic [3:0] cw;
  logic [4:0] status;
  logic [1:0] prio;
  logic [1:0] qidx;
  logic [9:0] sn;

  logic [31:0] st0, st1, st2, fs0, fs1, fs2;
  logic        irq0, irq1, irq2;
  logic [31:0] a_st [3];
  logic [31:0] a_fs [3];
  logic        a_irq [3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [31:0] mq [3][$];
  logic [15:0] mdrop [3];
  bit          m_cap;
  logic [31:0] m_rec;

  always #5 clk = ~clk;

  tx_status_fifo_mq #(.DEPTH(64), .POP_ADDR(5'h16), .STAT_ADDR(5'h17), .IRQ_THRESH(48), .OVERWRITE(1'b0)) u_dut0 (
    .clk(clk), .rstn(rstn), .slv_reg_rden(rden), .axi_araddr_core(araddr), .tx_try_complete(txc),
    .num_slot_random(nsr), .cw(cw), .tx_status(status), .linux_prio(prio), .tx_queue_idx(qidx),
    .tx_pkt_sn(sn), .tx_status_out(st0), .fifo_stat_out(fs0), .irq_out(irq0));

  tx_status_fifo_mq #(.DEPTH(64), .POP_ADDR(5'h16), .STAT_ADDR(5'h17), .IRQ_THRESH(48), .OVERWRITE(1'b1)) u_dut1 (
    .clk(clk), .rstn(rstn), .slv_reg_rden(rden), .axi_araddr_core(araddr), .tx_try_complete(txc),
    .num_slot_random(nsr), .cw(cw), .tx_status(status), .linux_prio(prio), .tx_queue_idx(qidx),
    .tx_pkt_sn(sn), .tx_status_out(st1), .fifo_stat_out(fs1), .irq_out(irq1));

  tx_status_fifo_mq #(.DEPTH(4), .POP_ADDR(5'h16), .STAT_ADDR(5'h17), .IRQ_THRESH(3), .OVERWRITE(1'b0)) u_dut2 (
    .clk(clk), .rstn(rstn), .slv_reg_rden(rden), .axi_araddr_core(araddr), .tx_try_complete(txc),
    .num_slot_random(nsr), .cw(cw), .tx_status(status), .linux_prio(prio), .tx_queue_idx(qidx),
    .tx_pkt_sn(sn), .tx_status_out(st2), .fifo_stat_out(fs2), .irq_out(irq2));

  assign a_st[0] = st0;  assign a_st[1] = st1;  assign a_st[2] = st2;
  assign a_fs[0] = fs0;  assign a_fs[1] = fs1;  assign a_fs[2] = fs2;
  assign a_irq[0] = irq0; assign a_irq[1] = irq1; assign a_irq[2] = irq2;

  function automatic logic [31:0] pack(input logic [3:0] c, input logic [9:0] n, input logic [1:0] p,
                                       input logic [1:0] q, input logic [9:0] s, input logic [4:0] r);
    logic [3:0] cx;
    cx = c + {3'b000, n[9]};
    return {cx, n[8:0], p, q, s, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: a queue per configuration, updated on every active edge.
  initial begin
    bit do_pop;
    bit dropped;
    m_cap = 1'b0;
    m_rec = '0;
    for (int i = 0; i < 3; i++) mdrop[i] = '0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int i = 0; i < 3; i++) begin
          mq[i].delete();
          mdrop[i] = '0;
        end
        m_cap = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          do_pop  = rden && (araddr == c_pop) && (mq[i].size() > 0);
          dropped = 1'b0;
          if (do_pop) void'(mq[i].pop_front());
          if (m_cap) begin
            if (mq[i].size() < c_mdepth[i]) begin
              mq[i].push_back(m_rec);
            end else begin
              dropped = 1'b1;
              if (c_mow[i]) begin
                void'(mq[i].pop_front());
                mq[i].push_back(m_rec);
              end
            end
          end
          if (rden && (araddr == c_stat)) mdrop[i] = dropped ? 16'd1 : 16'd0;
          else if (dropped && (mdrop[i] != 16'hFFFF)) mdrop[i] = mdrop[i] + 16'd1;
        end
        m_cap = txc;
        m_rec = pack(cw, nsr, prio, qidx, sn, status);
      end
    end
  end

  initial begin
    int          lvl;
    logic [31:0] e_st;
    logic [31:0] e_fs;
    logic        e_irq;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < 3; i++) begin
          lvl   = mq[i].size();
          e_st  = (lvl > 0) ? mq[i][0] : 32'hFFFF_FFFF;
          e_irq = (lvl >= c_mthresh[i]);
          e_fs  = {mdrop[i], e_irq, 4'b0000, 11'(lvl)};
          chk($sformatf("model_tx_status_out[%0d]", i), a_st[i], e_st);
          chk($sformatf("model_fifo_stat_out[%0d]", i), a_fs[i], e_fs);
          chk($sformatf("model_irq_out[%0d]", i), {31'd0, a_irq[i]}, {31'd0, e_irq});
        end
      end
    end
  end

  initial begin
    rstn = 1'b1; rden = 1'b0; araddr = '0; txc = 1'b0;
    nsr = '0; cw = '0; status = '0; prio = '0; qidx = '0; sn = '0;
    #2 rstn = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_tx_status_out", st0, 32'hFFFF_FFFF);
    chk("reset_fifo_stat_out", fs0, 32'h0);
    chk("reset_irq_out", {31'd0, irq0}, 32'h0);
    rstn = 1'b1;

    // Single record, visible two cycles after the pulse.
    cw = 4'd4; nsr = 10'h205; prio = 2'd1; qidx = 2'd2; sn = 10'h3A5; status = 5'h03; txc = 1'b1;
    @(negedge clk); txc = 1'b0;
    chk("single_t1_empty", st0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("single_t2_record", st0, 32'h502B_74A3);
    chk("single_t2_level", fs0, 32'h0000_0001);
    rden = 1'b1; araddr = c_pop;
    @(negedge clk); rden = 1'b0;
    chk("single_pop_empty", st0, 32'hFFFF_FFFF);
    chk("single_pop_level", fs0, 32'h0);

    // Fill with sn 0..63, then sn 64 overflows.
    cw = '0; nsr = '0; prio = '0; qidx = '0; status = '0;
    for (int k = 0; k <= 64; k++) begin
      sn = 10'(k); txc = 1'b1;
      @(negedge clk);
    end
    txc = 1'b0;
    @(negedge clk);
    chk("full_drop_stat", fs0, 32'h0001_8040);
    chk("full_drop_head", st0, 32'h0000_0000);
    chk("full_ovw_stat", fs1, 32'h0001_8040);
    chk("full_ovw_head", st1, 32'h0000_0020);
    chk("d4_drop_stat", fs2, 32'h003D_8004);
    chk("d4_drop_head", st2, 32'h0000_0000);

    // Status read clears drop_cnt after showing the old value.
    rden = 1'b1; araddr = c_stat;
    chk("stat_pre_read", fs0, 32'h0001_8040);
    @(negedge clk); rden = 1'b0;
    chk("stat_cleared", fs0, 32'h0000_8040);
    chk("d4_stat_cleared", fs2, 32'h0000_8004);

    // Push and pop on the same edge while full.
    sn = 10'd100; txc = 1'b1;
    @(negedge clk); txc = 1'b0; rden = 1'b1; araddr = c_pop;
    @(negedge clk); rden = 1'b0;
    chk("pushpop_stat", fs0, 32'h0000_8040);
    chk("pushpop_head", st0, 32'h0000_0020);
    chk("pushpop_ovw_head", st1, 32'h0000_0040);
    chk("pushpop_d4_head", st2, 32'h0000_0020);

    // Drain, then pop an empty FIFO five times.
    rden = 1'b1; araddr = c_pop;
    repeat (66) @(negedge clk);
    rden = 1'b0;
    chk("drained_head", st0, 32'hFFFF_FFFF);
    chk("drained_stat", fs0, 32'h0);
    rden = 1'b1;
    repeat (5) @(negedge clk);
    rden = 1'b0;
    chk("empty_pop_head", st0, 32'hFFFF_FFFF);
    chk("empty_pop_stat", fs0, 32'h0);
    chk("empty_pop_d4_stat", fs2, 32'h0);

    // Threshold interrupt around level 48.
    for (int k = 0; k < 47; k++) begin
      sn = 10'(k); txc = 1'b1;
      @(negedge clk);
    end
    txc = 1'b0;
    @(negedge clk);
    chk("lvl47_stat", fs0, 32'h0000_002F);
    chk("lvl47_irq", {31'd0, irq0}, 32'h0);
    chk("d4_lvl_drops", fs2, 32'h002B_8004);
    sn = 10'd47; txc = 1'b1;
    @(negedge clk); txc = 1'b0; rden = 1'b1; araddr = c_stat;
    chk("irq_before_write", {31'd0, irq0}, 32'h0);
    chk("stat_drop_pre", fs2, 32'h002B_8004);
    @(negedge clk); rden = 1'b0;
    chk("irq_after_write", {31'd0, irq0}, 32'h1);
    chk("lvl48_stat", fs0, 32'h0000_8030);
    chk("stat_drop_after", fs2, 32'h0001_8004);
    rden = 1'b1; araddr = c_pop;
    @(negedge clk); rden = 1'b0;
    chk("irq_after_pop", {31'd0, irq0}, 32'h0);
    chk("lvl47_after_pop", fs0, 32'h0000_002F);

    // Random traffic with a mid-capture asynchronous reset.
    for (int k = 0; k < 200; k++) begin
      txc    = 1'($urandom_range(0, 1));
      cw     = 4'($urandom);
      nsr    = 10'($urandom);
      prio   = 2'($urandom);
      qidx   = 2'($urandom);
      sn     = 10'($urandom);
      status = 5'($urandom);
      rden   = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0, 1:    araddr = c_pop;
        2:       araddr = c_stat;
        default: araddr = 5'($urandom);
      endcase
      if (k == 120) begin
        txc = 1'b1; rden = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0; txc = 1'b0;
        #1;
        chk("async_rst_head0", st0, 32'hFFFF_FFFF);
        chk("async_rst_stat1", fs1, 32'h0);
        chk("async_rst_head2", st2, 32'hFFFF_FFFF);
        chk("async_rst_irq0", {31'd0, irq0}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    txc = 1'b0; rden = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
